// File: rtl/wvb_dpram_drain.sv
// wvb_dpram_drain: consumer side of the waveform-buffer DPRAM handshake.
// Reads the 32-bit words the reader left in the DPRAM and streams them as
// 16-bit halfwords (low half first) on a valid/ready link, then pulses
// dpram_done so the reader can reuse the buffer.
// Optional feature: define WVB_DRAIN_CRC_EN to append a CRC-16/CCITT
// halfword (poly 0x1021, init 0xFFFF, MSB first) after the payload.
module wvb_dpram_drain #(
    parameter int P_ADR_WIDTH = 10,
    parameter int P_LEN_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dpram_run,
    input  logic [P_LEN_WIDTH-1:0] dpram_len,
    output logic                   dpram_busy,
    output logic                   dpram_done,
    output logic [P_ADR_WIDTH-1:0] rd_addr,
    input  logic [31:0]            rd_data,
    output logic [15:0]            out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   len_err,
    output logic [7:0]             run_ignored_cnt
);

    // Buffer capacity in halfwords: two per 32-bit word.
    localparam longint unsigned LC_CAP = 64'd2 << P_ADR_WIDTH;
    localparam logic [P_LEN_WIDTH-1:0] LC_ONE = P_LEN_WIDTH'(1);
    localparam logic [P_LEN_WIDTH-1:0] LC_TWO = P_LEN_WIDTH'(2);

`ifdef WVB_DRAIN_CRC_EN
    // With the CRC trailer the last flag belongs to the CRC halfword.
    localparam bit LC_PAYLOAD_LAST = 1'b0;
`else
    localparam bit LC_PAYLOAD_LAST = 1'b1;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SEND_LO,
        ST_SEND_HI,
        ST_DONE
`ifdef WVB_DRAIN_CRC_EN
        , ST_SEND_CRC
`endif
    } state_t;

    state_t                 state_q;
    logic                   busy_q;
    logic                   done_q;
    logic [P_ADR_WIDTH-1:0] addr_q;
    logic [15:0]            hi_q;
    logic [P_LEN_WIDTH-1:0] rem_q;
    logic [15:0]            data_q;
    logic                   valid_q;
    logic                   last_q;
    logic                   err_q;
    logic                   run_prev_q;
    logic [7:0]             ign_q;

    logic                   len_over;
    logic [P_LEN_WIDTH-1:0] req_len_d;

`ifdef WVB_DRAIN_CRC_EN
    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // One CRC-16/CCITT update over a 16-bit halfword, MSB first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // CRC including the halfword currently on the link.
    always_comb begin
        crc_d = crc16_step(crc_q, data_q);
    end
`endif

    // Clamp the requested length to what the DPRAM can actually hold.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
        len_over  = 1'b0;
        req_len_d = dpram_len;
        if (64'(dpram_len) > LC_CAP) begin
            len_over  = 1'b1;
            req_len_d = LC_CAP[P_LEN_WIDTH-1:0];
        end
    end

    // Transfer FSM with registered outputs, plus ignored-run edge counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: state uses non-blocking assignments so every register sees pre-edge values, independent of statement order.
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            hi_q       <= '0;
            rem_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            run_prev_q <= 1'b0;
            ign_q      <= '0;
`ifdef WVB_DRAIN_CRC_EN
            crc_q      <= 16'hFFFF;
`endif
        end else begin
            done_q     <= 1'b0;
            run_prev_q <= dpram_run;
            if (dpram_run && !run_prev_q && state_q != ST_IDLE && ign_q != 8'hFF) begin
                ign_q <= ign_q + 8'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (dpram_run) begin
                        busy_q <= 1'b1;
                        rem_q  <= req_len_d;
                        if (len_over) err_q <= 1'b1;
`ifdef WVB_DRAIN_CRC_EN
                        crc_q  <= 16'hFFFF;
`endif
                        if (req_len_d == '0) begin
`ifdef WVB_DRAIN_CRC_EN
                            state_q <= ST_SEND_CRC;
                            data_q  <= 16'hFFFF;
                            valid_q <= 1'b1;
                            last_q  <= 1'b1;
`else
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            addr_q  <= '0;
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: state_q <= ST_WAIT;
                ST_WAIT: begin
                    hi_q    <= rd_data[31:16];
                    data_q  <= rd_data[15:0];
                    valid_q <= 1'b1;
                    last_q  <= LC_PAYLOAD_LAST && (rem_q == LC_ONE);
                    state_q <= ST_SEND_LO;
                end
                ST_SEND_LO, ST_SEND_HI: begin
                    if (out_ready) begin
                        rem_q <= rem_q - LC_ONE;
`ifdef WVB_DRAIN_CRC_EN
                        crc_q <= crc_d;
`endif
                        if (rem_q == LC_ONE) begin
`ifdef WVB_DRAIN_CRC_EN
                            state_q <= ST_SEND_CRC;
                            data_q  <= crc_d;
                            last_q  <= 1'b1;
`else
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
`endif
                        end else if (state_q == ST_SEND_LO) begin
                            state_q <= ST_SEND_HI;
                            data_q  <= hi_q;
                            last_q  <= LC_PAYLOAD_LAST && (rem_q == LC_TWO);
                        end else begin
                            addr_q  <= addr_q + P_ADR_WIDTH'(1);
                            state_q <= ST_FETCH;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end
                    end
                end
`ifdef WVB_DRAIN_CRC_EN
                ST_SEND_CRC: begin
                    if (out_ready) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dpram_busy      = busy_q;
    assign dpram_done      = done_q;
    assign rd_addr         = addr_q;
    assign out_data        = data_q;
    assign out_valid       = valid_q;
    assign out_last        = last_q;
    assign len_err         = err_q;
    assign run_ignored_cnt = ign_q;

endmodule
